key_mix: RTL



---
 rtl/key_mix.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/key_mix.sv
// key_mix: RC5-style key schedule mixing pass over the S and L tables.
// Optional KEY_MIX_ABORT_EN adds iAbort, which returns a busy block to IDLE.
module key_mix #(
    parameter int T = 16,
    parameter int C = 4,
    parameter int W = 32,
    localparam int TL = $clog2(T),
    localparam int CL = $clog2(C),
    localparam int RL = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iStart,
`ifdef KEY_MIX_ABORT_EN
    input  logic          iAbort,
`endif
    output logic [TL-1:0] oS_address,
    input  logic [W-1:0]  iS_data,
    output logic [W-1:0]  oS_data,
    output logic          oS_we,
    output logic [CL-1:0] oL_address,
    input  logic [W-1:0]  iL_data,
    output logic [W-1:0]  oL_data,
    output logic          oL_we,
    output logic          oBusy,
    output logic          oDone
);
    localparam int N  = 3 * ((T > C) ? T : C);
    localparam int KL = $clog2(N + 1);
    localparam logic [TL-1:0] TMAX = TL'(T - 1);
    localparam logic [CL-1:0] CMAX = CL'(C - 1);
    localparam logic [KL-1:0] KLAST = KL'(N - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, CALC_A, WRITE_S, CALC_B, WRITE_L, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, rl_q, rl_d;
    logic [TL-1:0] i_q, i_d;
    logic [CL-1:0] j_q, j_d;
    logic [KL-1:0] k_q, k_d;
    logic [TL-1:0] s_addr_q, s_addr_d;
    logic [CL-1:0] l_addr_q, l_addr_d;
    logic [W-1:0]  s_data_q, s_data_d, l_data_q, l_data_d;
    logic          s_we_q, s_we_d, l_we_q, l_we_d, busy_q, busy_d, done_q, done_d;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RL-1:0] s);
        logic [2*W-1:0] t;
        t = {x, x} << s;
        return t[2*W-1:W];
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rl_d    = rl_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (iStart) begin
                state_d = READ;
                a_d     = '0;
                b_d     = '0;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
            end
            READ:    state_d = WAIT;
            WAIT:    state_d = CALC_A;
            CALC_A: begin
                a_d     = rotl(iS_data + a_q + b_q, RL'(3));
                rl_d    = iL_data;
                state_d = WRITE_S;
            end
            WRITE_S: state_d = CALC_B;
            CALC_B: begin
                b_d     = rotl(rl_q + a_q + b_q, RL'(a_q + b_q));
                state_d = WRITE_L;
            end
            WRITE_L: begin
                i_d     = (i_q == TMAX) ? '0 : i_q + 1'b1;
                j_d     = (j_q == CMAX) ? '0 : j_q + 1'b1;
                k_d     = k_q + 1'b1;
                state_d = (k_q == KLAST) ? DONE : READ;
            end
            DONE:    state_d = iStart ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
`ifdef KEY_MIX_ABORT_EN
        if (iAbort && state_q != IDLE && state_q != DONE) state_d = IDLE;
`endif
        // Outputs are decoded from the next state so they register alongside it.
        s_addr_d = (state_d inside {READ, WAIT, CALC_A, WRITE_S}) ? i_d : '0;
        l_addr_d = (state_d inside {READ, WAIT, CALC_A, WRITE_L}) ? j_d : '0;
        s_we_d   = state_d == WRITE_S;
        l_we_d   = state_d == WRITE_L;
        s_data_d = s_we_d ? a_d : '0;
        l_data_d = l_we_d ? b_d : '0;
        busy_d   = !(state_d inside {IDLE, DONE});
        done_d   = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rl_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            s_addr_q <= '0;
            l_addr_q <= '0;
            s_data_q <= '0;
            l_data_q <= '0;
            s_we_q   <= 1'b0;
            l_we_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rl_q     <= rl_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            s_addr_q <= s_addr_d;
            l_addr_q <= l_addr_d;
            s_data_q <= s_data_d;
            l_data_q <= l_data_d;
            s_we_q   <= s_we_d;
            l_we_q   <= l_we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oS_address = s_addr_q;
    assign oL_address = l_addr_q;
    assign oS_data    = s_data_q;
    assign oL_data    = l_data_q;
    assign oS_we      = s_we_q;
    assign oL_we      = l_we_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
endmodule
